// File: rtl/seg_display_driver.sv
// seg_display_driver: double-dabble BCD converter feeding a 4-digit multiplexed seven-segment display
module seg_display_driver #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] number,
   input  logic [1:0]  select,
   input  logic [1:0]  mode,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic [15:0] bcd,
   output logic        bcd_valid
);
   localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state_q, state_d;
   logic [13:0] bin_q, bin_d, last_q, last_d, sat;
   logic [15:0] scratch_q, scratch_d, adj, bcd_q, bcd_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        bcd_valid_q, bcd_valid_d;
   logic [RW-1:0] scan_q, scan_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic [1:0]  slot_q, slot_d;
   logic        blink_on_q, blink_on_d, wrap, bwrap, blank;
   logic [3:0]  an_q, an_d, digit;
   logic [6:0]  seg_q, seg_d, mode_seg, sel_seg;
   logic        dp_q, dp_d;
   function automatic logic [6:0] dec(input logic [3:0] d);
      case (d)
         4'd0: dec = 7'b1000000;
         4'd1: dec = 7'b1111001;
         4'd2: dec = 7'b0100100;
         4'd3: dec = 7'b0110000;
         4'd4: dec = 7'b0011001;
         4'd5: dec = 7'b0010010;
         4'd6: dec = 7'b0000010;
         4'd7: dec = 7'b1111000;
         4'd8: dec = 7'b0000000;
         4'd9: dec = 7'b0010000;
         default: dec = 7'b1111111;
      endcase
   endfunction
   assign sat = number > 14'd9999 ? 14'd9999 : number;
   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      scratch_d   = scratch_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      bcd_d       = bcd_q;
      bcd_valid_d = 1'b0;
      adj         = scratch_q;
      for (int i = 0; i < 4; i++)
         adj[4*i+:4] = scratch_q[4*i+:4] >= 4'd5 ? scratch_q[4*i+:4] + 4'd3 : scratch_q[4*i+:4];
      case (state_q)
         IDLE:
            if (sat != last_q) begin
               bin_d     = sat;
               scratch_d = 16'h0;
               last_d    = sat;
               cnt_d     = 4'd13;
               state_d   = SHIFT;
            end
         SHIFT: begin
            scratch_d = {adj[14:0], bin_q[13]};
            bin_d     = {bin_q[12:0], 1'b0};
            cnt_d     = cnt_q - 4'd1;
            state_d   = cnt_q == 4'd0 ? DONE : SHIFT;
         end
         DONE: begin
            bcd_d       = scratch_q;
            bcd_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // display registers are refreshed only on slot boundaries, using the incoming slot and blink phase
   always_comb begin
      wrap        = scan_q == RW'(REFRESH_DIV - 1);
      bwrap       = blink_cnt_q == BW'(BLINK_DIV - 1);
      scan_d      = wrap ? '0 : scan_q + RW'(1);
      slot_d      = wrap ? slot_q + 2'd1 : slot_q;
      blink_cnt_d = bwrap ? '0 : blink_cnt_q + BW'(1);
      blink_on_d  = bwrap ? ~blink_on_q : blink_on_q;
      digit       = bcd_q[4*slot_d+:4];
      mode_seg    = mode == 2'd3 ? 7'b0111111 : dec({2'b00, mode});
      sel_seg     = select == 2'd0 ? mode_seg : dec(digit);
      blank       = select == 2'd0 && (slot_d != 2'd0 || !blink_on_d);
      an_d        = wrap ? (blank ? 4'b1111 : ~(4'b0001 << slot_d)) : an_q;
      seg_d       = wrap ? (blank ? 7'b1111111 : sel_seg) : seg_q;
      dp_d        = wrap ? ~(select == 2'd3 && slot_d == 2'd3) : dp_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bin_q       <= '0;
         scratch_q   <= '0;
         cnt_q       <= '0;
         last_q      <= '0;
         bcd_q       <= '0;
         bcd_valid_q <= 1'b0;
         scan_q      <= '0;
         slot_q      <= '0;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
         an_q        <= 4'b1111;
         seg_q       <= 7'b1111111;
         dp_q        <= 1'b1;
      end else begin
         state_q     <= state_d;
         bin_q       <= bin_d;
         scratch_q   <= scratch_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         bcd_q       <= bcd_d;
         bcd_valid_q <= bcd_valid_d;
         scan_q      <= scan_d;
         slot_q      <= slot_d;
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
      end
   end
   assign seg       = seg_q;
   assign dp        = dp_q;
   assign an        = an_q;
   assign bcd       = bcd_q;
   assign bcd_valid = bcd_valid_q;
endmodule

// File: tb/tb_seg_display_driver.sv
// tb_seg_display_driver: directed scoreboard bench for seg_display_driver (REFRESH_DIV=4, BLINK_DIV=16)
module tb_seg_display_driver;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [13:0] number = 14'd1234;
   logic [1:0]  select = 2'd2;
   logic [1:0]  mode = 2'd0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic [15:0] bcd;
   logic        bcd_valid;
   int checks = 0, failures = 0, nvalid = 0, n0 = 0;
   logic [15:0] exp_q [$];
   logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   int scan_dig [0:3] = '{5, 0, 3, 0};
   int score_dig [0:3] = '{0, 2, 1, 0};
   always #5 clk = ~clk;
   seg_display_driver #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (
      .clk(clk), .rst(rst), .number(number), .select(select), .mode(mode),
      .seg(seg), .dp(dp), .an(an), .bcd(bcd), .bcd_valid(bcd_valid)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // every clock advance goes through here so each bcd_valid pulse is scored against the queue
   task automatic tick();
      logic [15:0] e;
      @(posedge clk);
      #1;
      if (bcd_valid) begin
         nvalid++;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else e = 16'hxxxx;
         chk("bcd_pop", 32'(bcd), 32'(e));
      end
   endtask
   task automatic wait_valid(input string tag, input int budget, input int exp_lat);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!bcd_valid && n < budget);
      chk(tag, 32'(n), 32'(exp_lat));
   endtask
   task automatic sync_slot0(input string tag);
      int n = 0;
      while (an == 4'b1110 && n < 80) begin tick(); n++; end
      while (an != 4'b1110 && n < 80) begin tick(); n++; end
      chk(tag, 32'(an), 32'hE);
   endtask
   initial begin
      logic [3:0] ea;
      int s;
      repeat (3) tick();
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_dp", 32'(dp), 32'h1);
      chk("rst_bcd", 32'(bcd), 32'h0);
      chk("rst_valid", 32'(bcd_valid), 32'h0);
      rst = 1'b0;
      exp_q.push_back(16'h1234);
      wait_valid("rst_lat", 40, 16);
      number = 14'd16383;
      exp_q.push_back(16'h9999);
      wait_valid("sat_lat", 40, 16);
      number = 14'd9999;
      n0 = nvalid;
      repeat (30) tick();
      chk("sat_noconv", 32'(nvalid - n0), 32'h0);
      number = 14'd42;
      exp_q.push_back(16'h0042);
      repeat (6) tick();
      number = 14'd7000;
      exp_q.push_back(16'h7000);
      n0 = nvalid;
      wait_valid("mid_lat1", 40, 10);
      wait_valid("mid_lat2", 40, 16);
      chk("mid_count", 32'(nvalid - n0), 32'h2);
      number = 14'd305;
      exp_q.push_back(16'h0305);
      wait_valid("scan_lat", 40, 16);
      sync_slot0("scan_sync");
      for (int c = 0; c < 16; c++) begin
         s = c / 4;
         ea = ~(4'b0001 << s);
         chk("scan_an", 32'(an), 32'(ea));
         chk("scan_seg", 32'(seg), 32'(seg_tab[scan_dig[s]]));
         chk("scan_dp", 32'(dp), 32'h1);
         tick();
      end
      select = 2'd0;
      mode = 2'd2;
      sync_slot0("mode_sync");
      for (int c = 0; c < 32; c++) begin
         ea = (c < 4) ? 4'b1110 : 4'b1111;
         chk("blink_an", 32'(an), 32'(ea));
         if (c < 4) chk("mode_seg", 32'(seg), 32'(7'b0100100));
         chk("mode_dp", 32'(dp), 32'h1);
         tick();
      end
      chk("blink_period", 32'(an), 32'hE);
      mode = 2'd3;
      sync_slot0("dash_sync");
      chk("dash_seg", 32'(seg), 32'(7'b0111111));
      select = 2'd3;
      number = 14'd120;
      exp_q.push_back(16'h0120);
      wait_valid("score_lat", 40, 16);
      sync_slot0("score_sync");
      for (int c = 0; c < 32; c++) begin
         s = (c / 4) % 4;
         ea = ~(4'b0001 << s);
         chk("score_an", 32'(an), 32'(ea));
         chk("score_seg", 32'(seg), 32'(seg_tab[score_dig[s]]));
         chk("score_dp", 32'(dp), (s == 3 && c < 16) ? 32'h0 : 32'h1);
         if (c == 13) select = 2'd1;
         tick();
      end
      chk("q_empty", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/seg_display_driver.md
Name: seg_display_driver

Overview:
- Display-side consumer of the game controller's select/mode/number outputs; drives the board's 4-digit common-anode seven-segment display.
- Converts the 14-bit binary number to 4 BCD digits with a sequential double-dabble engine.
- Time-multiplexes the four digits and selects what is shown from the game phase (select).
- Blinks the difficulty digit during mode selection.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz).
- BLINK_DIV, 25000000, clk cycles per blink half-period (2 Hz toggle at 100 MHz).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- number  input  14  binary value to display; values above 9999 saturate to 9999.
- select  input  2  game phase: 0 mode-select, 1 target shown, 2 counting, 3 score.
- mode  input  2  difficulty: 0 easy, 1 regular, 2 hard, 3 invalid.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- an  output  4  digit anodes, active-low; an[0] is the rightmost digit.
- bcd  output  16  last converted digits {thousands,hundreds,tens,ones}.
- bcd_valid  output  1  one-cycle pulse when bcd updates.

Behaviour:
- Reset values (all outputs registered): an=4'b1111, seg=7'b1111111, dp=1, bcd=0, bcd_valid=0. FSM is IDLE, last_conv=0, scan counter=0, slot=0, blink counter=0, blink phase=on.
- Converter FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - If the saturated number differs from last_conv, load it into the shift register, clear the BCD scratch, set last_conv to the loaded value, and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, 14 cycles, bit counter 13 down to 0:
  - Each cycle, add 3 to every BCD nibble that is at least 5.
  - Then shift {bcd_scratch, bin} left by 1.
  - After the 14th shift, go to DONE.
- DONE, 1 cycle: copy scratch to bcd, pulse bcd_valid, return to IDLE.
- Latency: a change on number is sampled in IDLE; bcd and bcd_valid update 16 cycles later (1 load + 14 shift + 1 done edge).
- Number changing mid-conversion: the current conversion completes with the old value. Its result is published. IDLE then sees the mismatch and restarts. bcd never shows a partial result.
- The first conversion after reset happens only once number is nonzero. bcd=0 is already correct for number=0.
- Scan counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, slot advances 0→1→2→3→0.
  - an = ~(4'b0001 << slot) unless the slot is blanked; a blanked slot drives an=4'b1111.
- Blink counter: counts 0..BLINK_DIV-1; on wrap, the blink phase toggles. Counts continuously in all phases.
- Content for select=0:
  - Slot 0 shows the mode digit 0/1/2; mode=3 shows a dash (seg=7'b0111111).
  - Slot 0 is blanked while the blink phase is off.
  - Slots 1-3 are blanked.
  - dp=1.
- Content for select=1, 2 or 3:
  - All four slots show bcd digits (slot 0 = ones), with leading zeros shown.
  - dp is 0 on slot 3 only when select=3, marking the score phase; otherwise dp=1.
- Segment decode for digits 0-9 is standard active-low. Nibble values 10-15 cannot occur after saturation; if forced, they display blank.
- select changes are reflected from the next slot update. seg, dp and an change only together, in the same cycle.
- The converter runs independently of select.

Test Plan (REFRESH_DIV=4, BLINK_DIV=16):
- Reset: assert rst for 3 cycles with number=1234 → an=1111, seg=1111111, dp=1, bcd=0, bcd_valid=0. After release, bcd_valid pulses exactly 16 cycles later with bcd=16'h1234.
- Saturation: number=14'd16383 → bcd=16'h9999; then number=9999 → no new conversion and no bcd_valid pulse.
- Mid-conversion change: number 42→7000 at SHIFT cycle 5 → bcd_valid with 16'h0042, then 16'h7000 is published 16 cycles after returning to IDLE. No other bcd values appear.
- Scan with select=2, bcd=16'h0305:
  - an cycles 1110,1101,1011,0111, changing every 4 clk.
  - seg cycles 7'b0010010 (5), 7'b1000000 (0), 7'b0110000 (3), 7'b1000000 (0).
  - dp=1 throughout.
- Mode phase with select=0, mode=2:
  - While the blink phase is on, slot 0 shows seg=7'b0100100 (2) with an=1110, and slots 1-3 give an=1111.
  - While the blink phase is off, all slots give an=1111.
  - The blink phase toggles every 16 clk.
  - mode=3 shows seg=7'b0111111.
- Score marker: select=3, bcd=16'h0120 → dp=0 only while an=0111. Switching to select=1 → dp=1 from the next slot.
